rsc_encoder_term: RTL and testbench
===================================

Name: rsc_encoder_term

Overview:
- Single 8-state recursive systematic convolutional (RSC) constituent encoder with trellis termination.
- Transmit-side counterpart of the max-log-MAP alpha/beta pipeline stages: it produces the systematic, parity and tail bit streams that those stages decode.
- Two instances plus an interleaver form the turbo encoder.
- Carries the same Enable / Error_previous stall gating and Razor-style error flag as the decoder pipeline stages.

Parameters:
- K_MAX, 6144, largest supported block length in information bits.
- LW, 13, width of Block_len; must satisfy 2^LW > K_MAX.

Ports:
- Clock  in  1  rising-edge clock
- nReset  in  1  asynchronous active-low reset
- nClear  in  1  asynchronous active-low clear; same effect as nReset
- Enable  in  1  global advance enable
- Error_previous  in  1  timing error from upstream stage; stalls this stage for the cycle
- Start  in  1  begin a block; sampled only in IDLE
- Block_len  in  LW  information bits in the block; sampled with Start
- in_bit  in  1  information bit
- in_valid  in  1  in_bit valid
- in_ready  out  1  encoder accepts in_bit this cycle
- out_sys  out  1  systematic bit (tail systematic during termination)
- out_par  out  1  parity bit
- out_tail  out  1  current output bit pair is a tail pair
- out_valid  out  1  out_sys/out_par valid
- out_ready  in  1  downstream accepts the output pair
- Done  out  1  one-cycle pulse when the last tail pair is accepted
- Error_current  out  1  timing error detected on the state register

Behaviour:
- Reset (nReset or nClear low, asynchronous):
  - FSM goes to IDLE; state s1,s2,s3 = 0; counter = 0.
  - All outputs 0, including in_ready, out_valid and Error_current.
- adv = Enable && !Error_previous. Nothing below changes state when adv = 0; outputs hold.
- Trellis (feedback 1+D^2+D^3, feedforward 1+D+D^3):
  - a = x ^ s2 ^ s3
  - z = a ^ s1 ^ s3
  - on each step: s3 <= s2, s2 <= s1, s1 <= a
- FSM IDLE:
  - in_ready = 0.
  - Start && adv: latch len = min(Block_len, K_MAX), counter = 0.
  - Go to ENCODE, or directly to TAIL when len = 0.
- FSM ENCODE:
  - in_ready = adv && (!out_valid || out_ready).
  - On in_valid && in_ready:
    - register out_sys = in_bit, out_par = z, out_tail = 0, out_valid = 1;
    - step the trellis and increment the counter;
    - when the counter reaches len, go to TAIL.
- FSM TAIL, 3 steps:
  - Each step x = s2 ^ s3, which forces a = 0; z = s1 ^ s3.
  - A step fires when adv && (!out_valid || out_ready); it registers out_sys = x, out_par = z, out_tail = 1, out_valid = 1.
  - After the 3rd step go to DRAIN.
- FSM DRAIN: when the final pair is accepted (out_ready), pulse Done for 1 cycle, clear out_valid, go to IDLE.
- Timing and flow control:
  - Latency is one cycle from input acceptance to out_valid.
  - Throughput is 1 bit/cycle when out_ready stays high.
  - out_valid and the out_* values hold stable until out_ready.
  - out_valid clears on acceptance when no new pair is produced in the same cycle.
- Boundary conditions:
  - After the 3 tail steps, state is always 000.
  - Start outside IDLE is ignored.
  - in_valid outside ENCODE is ignored.
  - Reset mid-block abandons the block with no Done pulse.
  - Error_previous asserted in the same cycle as a handshake: the bit is not consumed; in_ready is 0 that cycle.

Optional Feature:
- Macro RSC_RAZOR_EN.
- When defined:
  - A shadow latch on s1..s3 is transparent while !Enable && !Error_previous && Clock, and cleared by nReset/nClear.
  - Error_current = OR over i of (latch_si ^ si).
- When undefined: Error_current is tied to 0 and no latch is inferred.

Test Plan:
- Reset, then Start with Block_len = 4 and bits 1,0,1,1, out_ready = 1 → out_par = 1,1,0,1 with out_tail = 0, then 3 tail pairs sys/par 0/0, 0/0, 0/0 (out_tail = 1), Done 1 cycle after the last pair.
- Block_len = 1, bit 1 → data pair 1/1, then tail pairs 0/1, 1/0, 1/1, Done; internal state 000 at end.
- Block_len = 4 stream with out_ready low for 3 cycles mid-block → in_ready = 0 during the stall, out_* stable, same output sequence as the first test.
- Error_previous pulsed for 2 cycles during ENCODE → no bits consumed and the output unchanged during the pulse; final parity is identical to the unstalled run.
- Block_len = 0 → exactly 3 tail pairs 0/0 and Done. Start asserted during TAIL is ignored.
- nReset asserted after 2 bits → all outputs 0 immediately. A new Block_len = 4 run with 1,0,1,1 reproduces 1,1,0,1.

Source files
------------

// File: rtl/rsc_encoder_term.sv
// rsc_encoder_term: 8-state recursive systematic convolutional encoder.
//   Feedback polynomial 1+D^2+D^3, feedforward 1+D+D^3.
//   Each block of len information bits is followed by 3 tail steps.
//   The tail steps drive the state register back to 000.
//   The output pair register uses a valid/ready handshake.
//   All state advance is gated by Enable && !Error_previous.
// Optional feature: define RSC_RAZOR_EN to add a shadow latch on s1..s3.
//   Error_current then flags a mismatch between the latch and the
//   register. Without the macro, Error_current is tied low.
module rsc_encoder_term #(
  parameter int K_MAX = 6144,
  parameter int LW    = 13
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic          nClear,
  input  logic          Enable,
  input  logic          Error_previous,
  input  logic          Start,
  input  logic [LW-1:0] Block_len,
  input  logic          in_bit,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_sys,
  output logic          out_par,
  output logic          out_tail,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          Done,
  output logic          Error_current
);

  typedef enum logic [1:0] {IDLE, ENCODE, TAIL, DRAIN} fsm_t;

  localparam logic [LW-1:0] K_MAX_L = LW'(K_MAX);

  fsm_t          state;
  logic          s1, s2, s3;
  logic [LW-1:0] len;
  logic [LW-1:0] count;
  logic [1:0]    tail_cnt;

  logic          rst_n;
  logic          adv;
  logic          slot_free;
  logic          take_bit;
  logic          tail_fire;
  logic          accept;
  logic          step_x;
  logic          fb;
  logic          par;
  logic [LW-1:0] len_clamped;

  // Either reset input clears the whole block.
  assign rst_n = nReset && nClear;

  // Handshake qualifiers and one trellis step for the current input.
  // During termination the input is chosen so that the feedback bit is 0.
  always_comb begin
    adv         = Enable && !Error_previous;
    slot_free   = !out_valid || out_ready;
    in_ready    = (state == ENCODE) && adv && slot_free;
    take_bit    = in_ready && in_valid;
    tail_fire   = (state == TAIL) && adv && slot_free;
    accept      = adv && out_valid && out_ready;
    step_x      = (state == TAIL) ? (s2 ^ s3) : in_bit;
    fb          = step_x ^ s2 ^ s3;
    par         = fb ^ s1 ^ s3;
    len_clamped = (Block_len > K_MAX_L) ? K_MAX_L : Block_len;
  end

  // Control FSM, trellis state and registered output pair.
  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      len       <= '0;
      count     <= '0;
      tail_cnt  <= 2'd0;
      out_sys   <= 1'b0;
      out_par   <= 1'b0;
      out_tail  <= 1'b0;
      out_valid <= 1'b0;
      Done      <= 1'b0;
    end else begin
      // Done is a single-cycle pulse.
      Done <= 1'b0;
      if (adv) begin
        case (state)
          IDLE: begin
            if (Start) begin
              len      <= len_clamped;
              count    <= '0;
              tail_cnt <= 2'd0;
              state    <= (len_clamped == '0) ? TAIL : ENCODE;
            end
          end
          ENCODE: begin
            if (take_bit) begin
              out_sys   <= in_bit;
              out_par   <= par;
              out_tail  <= 1'b0;
              out_valid <= 1'b1;
              s3        <= s2;
              s2        <= s1;
              s1        <= fb;
              count     <= count + LW'(1);
              if (count + LW'(1) == len) begin
                state <= TAIL;
              end
            end else if (accept) begin
              out_valid <= 1'b0;
            end
          end
          TAIL: begin
            if (tail_fire) begin
              out_sys   <= step_x;
              out_par   <= par;
              out_tail  <= 1'b1;
              out_valid <= 1'b1;
              s3        <= s2;
              s2        <= s1;
              s1        <= fb;
              tail_cnt  <= tail_cnt + 2'd1;
              if (tail_cnt == 2'd2) begin
                state <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (accept) begin
              Done      <= 1'b1;
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef RSC_RAZOR_EN
  logic [2:0] shadow;

  // Shadow copy of the state, open only while the stage is idle-enabled
  // in the clock-high phase.
  always_latch begin
    if (!rst_n) begin
      shadow <= 3'b000;
    end else if (!Enable && !Error_previous && Clock) begin
      shadow <= {s3, s2, s1};
    end
  end

  assign Error_current = |(shadow ^ {s3, s2, s1});
`else
  assign Error_current = 1'b0;
`endif

endmodule

// File: tb/tb_rsc_encoder_term.sv
// tb_rsc_encoder_term: table vectors, hand-written reset sequences and
// randomized blocks checked against a recurrence-based reference model.
module tb_rsc_encoder_term;

  localparam int K_MAX = 6144;
  localparam int LW    = 13;

  logic          clk = 1'b0;
  logic          nReset = 1'b1;
  logic          nClear = 1'b1;
  logic          Enable = 1'b1;
  logic          Error_previous = 1'b0;
  logic          Start = 1'b0;
  logic [LW-1:0] Block_len = '0;
  logic          in_bit = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          out_sys;
  logic          out_par;
  logic          out_tail;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          Done;
  logic          Error_current;

  rsc_encoder_term #(.K_MAX(K_MAX), .LW(LW)) dut (
    .Clock(clk), .nReset(nReset), .nClear(nClear), .Enable(Enable),
    .Error_previous(Error_previous), .Start(Start), .Block_len(Block_len),
    .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
    .out_sys(out_sys), .out_par(out_par), .out_tail(out_tail),
    .out_valid(out_valid), .out_ready(out_ready), .Done(Done),
    .Error_current(Error_current)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit       bits_q[$];
  logic [2:0] exp_q[$];
  logic [2:0] got_q[$];
  bit       collect = 0;
  int       done_cnt = 0;
  int       cyc_n = 0;
  int       last_acc = -1;
  int       done_cyc = -1;
  bit       prev_hold = 0;
  logic [2:0] prev_pair = 3'b000;

  typedef struct {
    int         len;
    logic [7:0] bits;
    logic [7:0] par;
    logic [2:0] tsys;
    logic [2:0] tpar;
    int         rdy_mode;
    int         err_mode;
    bit         noise;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Passive monitor: hold/gating rules and accepted-pair capture.
  always @(negedge clk) begin
    if (collect) begin
      logic acc;
      cyc_n++;
      if (prev_hold) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_pair", {29'd0, out_sys, out_par, out_tail}, {29'd0, prev_pair});
      end
      if (!Enable || Error_previous || (out_valid && !out_ready))
        chk("in_ready_gated", {31'd0, in_ready}, 32'd0);
`ifndef RSC_RAZOR_EN
      chk("error_current_low", {31'd0, Error_current}, 32'd0);
`endif
      acc = out_valid && out_ready && Enable && !Error_previous;
      if (acc) begin
        got_q.push_back({out_sys, out_par, out_tail});
        last_acc = cyc_n;
      end
      if (Done) begin
        done_cnt++;
        done_cyc = cyc_n;
      end
      prev_hold = out_valid && !acc;
      prev_pair = {out_sys, out_par, out_tail};
    end else begin
      prev_hold = 0;
    end
  end

  // Reference: a_k = x_k ^ a_{k-2} ^ a_{k-3}, parity = a_k ^ a_{k-1} ^ a_{k-3};
  // tail inputs are picked so that a_k = 0.
  task automatic build_model(input int eff);
    bit a[$];
    bit x, av, z;
    int n;
    exp_q.delete();
    a = '{1'b0, 1'b0, 1'b0};
    for (int k = 0; k < eff; k++) begin
      n  = a.size();
      x  = bits_q[k];
      av = x ^ a[n-2] ^ a[n-3];
      z  = av ^ a[n-1] ^ a[n-3];
      a.push_back(av);
      exp_q.push_back({x, z, 1'b0});
    end
    for (int t = 0; t < 3; t++) begin
      n = a.size();
      x = a[n-2] ^ a[n-3];
      z = a[n-1] ^ a[n-3];
      a.push_back(1'b0);
      exp_q.push_back({x, z, 1'b1});
    end
  endtask

  task automatic build_from_vec(input vec_t v);
    logic [7:0] b, p;
    logic [2:0] ts, tp;
    b = v.bits; p = v.par; ts = v.tsys; tp = v.tpar;
    bits_q.delete();
    exp_q.delete();
    for (int i = 0; i < v.len; i++) begin
      bits_q.push_back(b[i]);
      exp_q.push_back({b[i], p[i], 1'b0});
    end
    for (int j = 0; j < 3; j++) exp_q.push_back({ts[j], tp[j], 1'b1});
  endtask

  // Runs one block. rdy_mode/err_mode: 0 clean, 1 random, 2 fixed stall window.
  task automatic run_block(input int len_req, input int rdy_mode, input int err_mode, input bit noise);
    int eff;
    int idx;
    int cyc;
    eff = (len_req > K_MAX) ? K_MAX : len_req;
    idx = 0;
    cyc = 0;
    got_q.delete();
    done_cnt = 0; cyc_n = 0; last_acc = -1; done_cyc = -1;
    @(posedge clk); #1;
    collect = 1;
    Start = 1; Block_len = LW'(len_req); Enable = 1; Error_previous = 0;
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    Start = 0;
    while (done_cnt == 0 && cyc < 20000) begin
      if (rdy_mode == 1) begin
        in_valid = (idx < eff) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
        out_ready = ($urandom_range(0, 3) != 0);
        Enable = ($urandom_range(0, 7) != 0);
      end else begin
        in_valid = (idx < eff);
        out_ready = (rdy_mode == 2) ? !(cyc >= 2 && cyc <= 4) : 1'b1;
        Enable = 1;
      end
      in_bit = (idx < eff) ? bits_q[idx] : 1'($urandom_range(0, 1));
      if (err_mode == 1) Error_previous = ($urandom_range(0, 7) == 0);
      else if (err_mode == 2) Error_previous = (cyc == 2 || cyc == 3);
      else Error_previous = 0;
      if (noise && got_q.size() < eff + 3) begin
        Start = 1'($urandom_range(0, 1));
        Block_len = LW'($urandom_range(0, 50));
      end else begin
        Start = 0;
      end
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    Start = 0; in_valid = 0; out_ready = 1; Enable = 1; Error_previous = 0;
    chk("done_seen", {31'd0, done_cnt > 0}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    collect = 0;
    chk("done_once", done_cnt, 1);
    chk("done_latency", done_cyc, last_acc + 1);
    chk("bits_consumed", idx, eff);
    chk("final_state", {29'd0, dut.s1, dut.s2, dut.s3}, 32'd0);
    chk("pair_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("pair%0d", i), {29'd0, got_q[i]}, {29'd0, exp_q[i]});
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_sys"}, {31'd0, out_sys}, 32'd0);
    chk({tag, "_out_par"}, {31'd0, out_par}, 32'd0);
    chk({tag, "_out_tail"}, {31'd0, out_tail}, 32'd0);
    chk({tag, "_done"}, {31'd0, Done}, 32'd0);
    chk({tag, "_error"}, {31'd0, Error_current}, 32'd0);
  endtask

  // Starts a 4-bit block, feeds two bits, then pulls the chosen reset low.
  task automatic abort_mid_block(input bit use_clear);
    @(posedge clk); #1;
    Start = 1; Block_len = LW'(4); in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    Start = 0; in_valid = 1; in_bit = 1;
    @(posedge clk); #1;
    in_bit = 0;
    @(posedge clk); #1;
    in_valid = 0;
    chk("pre_abort_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_abort_pair", {29'd0, out_sys, out_par, out_tail}, {29'd0, 3'b010});
    #2;
    if (use_clear) nClear = 0; else nReset = 0;
    #1;
    check_outputs_zero(use_clear ? "clear" : "reset");
    @(posedge clk); #1;
    nClear = 1; nReset = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_done_after_abort", {31'd0, Done}, 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{4, 8'h0D, 8'h0B, 3'b000, 3'b000, 0, 0, 1'b0};
    vecs[1] = '{1, 8'h01, 8'h01, 3'b110, 3'b101, 0, 0, 1'b0};
    vecs[2] = '{4, 8'h0D, 8'h0B, 3'b000, 3'b000, 2, 0, 1'b0};
    vecs[3] = '{4, 8'h0D, 8'h0B, 3'b000, 3'b000, 0, 2, 1'b0};
    vecs[4] = '{0, 8'h00, 8'h00, 3'b000, 3'b000, 0, 0, 1'b1};
    vecs[5] = '{2, 8'h03, 8'h01, 3'b101, 3'b111, 1, 1, 1'b1};

    // Power-on reset.
    #2 nReset = 0;
    #1 check_outputs_zero("por");
    @(posedge clk); #1;
    nReset = 1;

    for (int v = 0; v < 6; v++) begin
      build_from_vec(vecs[v]);
      run_block(vecs[v].len, vecs[v].rdy_mode, vecs[v].err_mode, vecs[v].noise);
    end

    // Abort mid-block via each reset input, then a clean rerun.
    abort_mid_block(1'b0);
    build_from_vec(vecs[0]);
    run_block(4, 0, 0, 1'b0);
    abort_mid_block(1'b1);
    build_from_vec(vecs[0]);
    run_block(4, 0, 0, 1'b0);

    // Randomized blocks against the reference model.
    for (int b = 0; b < 25; b++) begin
      int len;
      len = $urandom_range(0, 40);
      bits_q.delete();
      for (int i = 0; i < len; i++) bits_q.push_back(1'($urandom_range(0, 1)));
      build_model(len);
      run_block(len, 1, 1, 1'($urandom_range(0, 1)));
    end

    // Oversized Block_len is clamped to K_MAX.
    bits_q.delete();
    for (int i = 0; i < K_MAX; i++) bits_q.push_back(1'($urandom_range(0, 1)));
    build_model(K_MAX);
    run_block(8000, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
